// File: rtl/mission_level_sequencer_pkg.sv
// mission_pkg: shared types and constants for the mission level sequencer.
// Holds the FSM state enum, per-level masks, command whitelists and status codes.
package mission_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_L1_SETTLE,
        S_L1_CHECK,
        S_L2_SETTLE,
        S_L2_CHECK,
        S_L2_CMD,
        S_L3_SETTLE,
        S_L3_CHECK,
        S_L3_CMD,
        S_DONE
    } state_t;

    localparam logic [4:0] L1_MASK = 5'b11110;
    localparam logic [4:0] L2_MASK = 5'b11100;
    localparam logic [4:0] L3_MASK = 5'b11000;

    localparam logic [4:0] L2_OFF_ALLOWED = 5'b00010;
    localparam logic [4:0] L3_OFF_ALLOWED = 5'b00110;

    localparam logic [1:0] STAT_RUN   = 2'b00;
    localparam logic [1:0] STAT_OK    = 2'b01;
    localparam logic [1:0] STAT_ABORT = 2'b10;
    localparam logic [1:0] STAT_FAIL  = 2'b11;

    // Clear only those requested bits that the current level lets the operator touch.
    function automatic logic [4:0] cmd_apply(
        input logic [4:0] cur,
        input logic [4:0] req,
        input logic [4:0] allowed
    );
        return cur & ~(req & allowed);
    endfunction

endpackage

// File: rtl/mission_level_sequencer_if.sv
// Operator command channel (valid/ready) for the mission level sequencer.
// cmd_valid/cmd_mask from operator (master), cmd_ready from sequencer (slave).
interface mission_level_sequencer_if;

    logic       cmd_valid;
    logic [4:0] cmd_mask;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_mask,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mask,
        output cmd_ready
    );

endinterface

// File: rtl/mission_level_sequencer_seq_timer.sv
// seq_timer: 8-bit loadable down-counter with a zero flag.
// Ports: clk, rst (async high), i_load, i_val[7:0] -> o_zero. Stops at zero.
module seq_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_val,
    output logic       o_zero
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/mission_level_sequencer.sv
// mission_level_sequencer: drives the three-level fault-tolerance chain.
// Ports: clk, rst (async high), start, r_in[4:0], lvl_pass[2:0], cmd (slave
// if: cmd_valid, cmd_mask, cmd_ready) -> e_mask, sw1_l2, sw1_l3, sw2_l3,
// lvl_sel, o_out, status, busy. Optional SEQ_CMD_TIMEOUT_EN: a CMD state
// with no handshake for CMD_TIMEOUT cycles advances with an empty mask.
module mission_level_sequencer
    import mission_pkg::*;
#(
    parameter int SETTLE_CYC  = 2,
    parameter int CMD_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [4:0]                 r_in,
    input  logic [2:0]                 lvl_pass,
    mission_level_sequencer_if.slave   cmd,
    output logic [4:0]                 e_mask,
    output logic                       sw1_l2,
    output logic                       sw1_l3,
    output logic                       sw2_l3,
    output logic [1:0]                 lvl_sel,
    output logic [4:0]                 o_out,
    output logic [1:0]                 status,
    output logic                       busy
);

    localparam logic [7:0] SETTLE_V = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] TMO_V    = 8'(CMD_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_e_mask;
    logic [4:0] w_e_mask_nxt;
    logic       r_sw1_l2;
    logic       w_sw1_l2_nxt;
    logic       r_sw1_l3;
    logic       w_sw1_l3_nxt;
    logic [1:0] r_lvl_sel;
    logic [1:0] w_lvl_sel_nxt;
    logic [4:0] r_o_out;
    logic [4:0] w_o_out_nxt;
    logic [1:0] r_status;
    logic [1:0] w_status_nxt;

    logic       w_tmr_load;
    logic [7:0] w_tmr_val;
    logic       w_tmr_zero;
    logic       w_cmd_ready;
    logic       w_hs;
    logic       w_cmd_go;
    logic [4:0] w_cmd_bits;

    // The same timer paces settle windows and, when enabled, command timeouts.
    seq_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tmr_load),
        .i_val  (w_tmr_val),
        .o_zero (w_tmr_zero)
    );

    assign w_cmd_ready = (r_state == S_L2_CMD) || (r_state == S_L3_CMD);
    assign w_hs        = cmd.cmd_valid && w_cmd_ready;

`ifdef SEQ_CMD_TIMEOUT_EN
    // A timeout behaves like a handshake carrying an empty mask.
    assign w_cmd_go   = w_hs || (w_cmd_ready && w_tmr_zero);
    assign w_cmd_bits = w_hs ? cmd.cmd_mask : 5'b00000;
`else
    assign w_cmd_go   = w_hs;
    assign w_cmd_bits = cmd.cmd_mask;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tmr_load    = 1'b0;
        w_tmr_val     = SETTLE_V;
        w_e_mask_nxt  = r_e_mask;
        w_sw1_l2_nxt  = r_sw1_l2;
        w_sw1_l3_nxt  = r_sw1_l3;
        w_lvl_sel_nxt = r_lvl_sel;
        w_o_out_nxt   = r_o_out;
        w_status_nxt  = r_status;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt   = S_L1_SETTLE;
                    w_tmr_load    = 1'b1;
                    w_e_mask_nxt  = L1_MASK;
                    w_sw1_l2_nxt  = 1'b0;
                    w_sw1_l3_nxt  = 1'b0;
                    w_lvl_sel_nxt = 2'd1;
                    w_o_out_nxt   = 5'b00000;
                    w_status_nxt  = STAT_RUN;
                end
            end
            S_L1_SETTLE: begin
                if (w_tmr_zero) w_state_nxt = S_L1_CHECK;
            end
            S_L1_CHECK: begin
                if (lvl_pass[0]) begin
                    w_o_out_nxt   = r_in & L1_MASK;
                    w_state_nxt   = S_L2_SETTLE;
                    w_tmr_load    = 1'b1;
                    w_e_mask_nxt  = L2_MASK;
                    w_sw1_l2_nxt  = 1'b1;
                    w_lvl_sel_nxt = 2'd2;
                end else begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = STAT_ABORT;
                end
            end
            S_L2_SETTLE: begin
                if (w_tmr_zero) w_state_nxt = S_L2_CHECK;
            end
            S_L2_CHECK: begin
                if (lvl_pass[1]) begin
                    w_o_out_nxt = r_in & L2_MASK;
                    w_state_nxt = S_L2_CMD;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TMO_V;
                end else begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = STAT_ABORT;
                end
            end
            S_L2_CMD: begin
                if (w_cmd_go) begin
                    w_o_out_nxt   = cmd_apply(r_o_out, w_cmd_bits, L2_OFF_ALLOWED);
                    w_state_nxt   = S_L3_SETTLE;
                    w_tmr_load    = 1'b1;
                    w_e_mask_nxt  = L3_MASK;
                    w_sw1_l3_nxt  = 1'b1;
                    w_lvl_sel_nxt = 2'd3;
                end
            end
            S_L3_SETTLE: begin
                if (w_tmr_zero) w_state_nxt = S_L3_CHECK;
            end
            S_L3_CHECK: begin
                if (lvl_pass[2]) begin
                    w_o_out_nxt = r_in & L3_MASK;
                    w_state_nxt = S_L3_CMD;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TMO_V;
                end else begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = STAT_FAIL;
                end
            end
            S_L3_CMD: begin
                if (w_cmd_go) begin
                    w_o_out_nxt  = cmd_apply(r_o_out, w_cmd_bits, L3_OFF_ALLOWED);
                    w_state_nxt  = S_DONE;
                    w_status_nxt = STAT_OK;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_mask  <= L1_MASK;
            r_sw1_l2  <= 1'b0;
            r_sw1_l3  <= 1'b0;
            r_lvl_sel <= 2'd0;
            r_o_out   <= 5'b00000;
            r_status  <= STAT_RUN;
        end else begin
            r_e_mask  <= w_e_mask_nxt;
            r_sw1_l2  <= w_sw1_l2_nxt;
            r_sw1_l3  <= w_sw1_l3_nxt;
            r_lvl_sel <= w_lvl_sel_nxt;
            r_o_out   <= w_o_out_nxt;
            r_status  <= w_status_nxt;
        end
    end

    assign e_mask        = r_e_mask;
    assign sw1_l2        = r_sw1_l2;
    assign sw1_l3        = r_sw1_l3;
    assign sw2_l3        = 1'b0;
    assign lvl_sel       = r_lvl_sel;
    assign o_out         = r_o_out;
    assign status        = r_status;
    assign busy          = (r_state != S_IDLE) && (r_state != S_DONE);
    assign cmd.cmd_ready = w_cmd_ready;

endmodule

// File: tb/tb_mission_level_sequencer.sv
// Testbench for mission_level_sequencer: directed missions, a timing-level
// reference model checked every cycle, and literal spot checks.
module tb_mission_level_sequencer;

    localparam int S = 2;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] r_in = 5'b00000;
    logic [2:0] lvl_pass = 3'b000;
    logic [4:0] e_mask;
    logic       sw1_l2, sw1_l3, sw2_l3;
    logic [1:0] lvl_sel;
    logic [4:0] o_out;
    logic [1:0] status;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    mission_level_sequencer_if cif ();

    mission_level_sequencer #(
        .SETTLE_CYC  (S),
        .CMD_TIMEOUT (T)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .r_in     (r_in),
        .lvl_pass (lvl_pass),
        .cmd      (cif.slave),
        .e_mask   (e_mask),
        .sw1_l2   (sw1_l2),
        .sw1_l3   (sw1_l3),
        .sw2_l3   (sw2_l3),
        .lvl_sel  (lvl_sel),
        .o_out    (o_out),
        .status   (status),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a mission is a level number plus cycles spent in it.
    bit         m_busy;
    bit         m_in_cmd;
    int         m_lvl;
    int         m_t;
    int         m_wait;
    logic [4:0] m_e;
    logic [4:0] m_o;
    logic       m_s2;
    logic       m_s3;
    logic [1:0] m_st;

    function automatic logic [4:0] lvl_mask(input int l);
        if (l == 1) return 5'b11110;
        if (l == 2) return 5'b11100;
        return 5'b11000;
    endfunction

    function automatic logic [4:0] lvl_allowed(input int l);
        if (l == 2) return 5'b00010;
        return 5'b00110;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_in_cmd = 0; m_lvl = 0; m_t = 0; m_wait = 0;
        m_e = 5'b11110; m_o = 5'b00000; m_s2 = 0; m_s3 = 0; m_st = 2'b00;
    endtask

    task automatic model_enter(input int l);
        m_lvl = l; m_t = 0; m_in_cmd = 0; m_wait = 0;
        m_e = lvl_mask(l);
        m_s2 = (l >= 2);
        m_s3 = (l == 3);
    endtask

    task automatic model_leave_cmd();
        if (m_lvl == 2) model_enter(3);
        else begin m_busy = 0; m_in_cmd = 0; m_st = 2'b01; end
    endtask

    task automatic model_step();
        if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_o = 5'b00000; m_st = 2'b00;
                model_enter(1);
            end
        end else if (m_in_cmd) begin
            if (cif.cmd_valid) begin
                m_o = m_o & ~(cif.cmd_mask & lvl_allowed(m_lvl));
                model_leave_cmd();
            end else begin
                m_wait++;
`ifdef SEQ_CMD_TIMEOUT_EN
                if (m_wait == T) model_leave_cmd();
`endif
            end
        end else if (m_t < S) begin
            m_t++;
        end else if (lvl_pass[m_lvl-1]) begin
            m_o = r_in & lvl_mask(m_lvl);
            if (m_lvl == 1) model_enter(2);
            else begin m_in_cmd = 1; m_wait = 0; end
        end else begin
            m_busy = 0;
            m_st = (m_lvl == 3) ? 2'b11 : 2'b10;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [17:0] act_v, exp_v;
        if (chk_en && !rst) begin
            act_v = {e_mask, sw1_l2, sw1_l3, sw2_l3, lvl_sel, o_out, status, busy, cif.cmd_ready};
            exp_v = {m_e, m_s2, m_s3, 1'b0, 2'(m_lvl), m_o, m_st, m_busy, m_busy & m_in_cmd};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle t=%0t got %b expected %b", $time, act_v, exp_v);
            end
        end
    end

    task automatic run_mission(input logic [4:0] rin, input logic [2:0] lp,
                               input logic [4:0] m2, input logic [4:0] m3,
                               output int cyc);
        r_in = rin; lvl_pass = lp;
        cif.cmd_valid = 1'b1; cif.cmd_mask = m2;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 300) begin
            cif.cmd_mask = (lvl_sel == 2'd3) ? m3 : m2;
            step();
            cyc++;
        end
        check("mission_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_e_mask"}, 32'(e_mask), 32'h1e);
        check({tag, "_sw"}, 32'({sw1_l2, sw1_l3, sw2_l3}), 32'd0);
        check({tag, "_lvl_sel"}, 32'(lvl_sel), 32'd0);
        check({tag, "_o_out"}, 32'(o_out), 32'd0);
        check({tag, "_status"}, 32'(status), 32'd0);
        check({tag, "_busy_rdy"}, 32'({busy, cif.cmd_ready}), 32'd0);
    endtask

    initial begin
        int cyc;
        cif.cmd_valid = 1'b0;
        cif.cmd_mask  = 5'b00000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        chk_en = 1'b1;
        step();

        // Full success: 11 edges after the start edge.
        run_mission(5'b11111, 3'b111, 5'b00010, 5'b00110, cyc);
        check("ok_cycles", 32'(cyc), 32'd11);
        check("ok_o_out", 32'(o_out), 32'h18);
        check("ok_status", 32'(status), 32'd1);
        step();

        // L1 abort.
        run_mission(5'b11111, 3'b000, 5'b00000, 5'b00000, cyc);
        check("abort_cycles", 32'(cyc), 32'd3);
        check("abort_status", 32'(status), 32'd2);
        check("abort_e_mask", 32'(e_mask), 32'h1e);
        check("abort_o_out", 32'(o_out), 32'd0);
        step();

        // L3 failure keeps L2 outputs.
        run_mission(5'b11111, 3'b011, 5'b00000, 5'b00000, cyc);
        check("fail_status", 32'(status), 32'd3);
        check("fail_sw1_l3", 32'(sw1_l3), 32'd1);
        check("fail_e_mask", 32'(e_mask), 32'h18);
        check("fail_o_out", 32'(o_out), 32'h1c);
        step();

        // Oversized L2 command and mixed health bits.
        run_mission(5'b10111, 3'b111, 5'b11111, 5'b11111, cyc);
        check("mask_o_out", 32'(o_out), 32'h10);
        check("mask_status", 32'(status), 32'd1);
        step();

        // Operator silent in L2_CMD.
        r_in = 5'b11111; lvl_pass = 3'b111;
        cif.cmd_valid = 1'b0; cif.cmd_mask = 5'b11111;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (!cif.cmd_ready && cyc < 20) begin step(); cyc++; end
        check("cmd_reached", 32'(cif.cmd_ready), 32'd1);
        repeat (100) step();
`ifdef SEQ_CMD_TIMEOUT_EN
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_o_out", 32'(o_out), 32'h18);
        check("tmo_status", 32'(status), 32'd1);
`else
        check("wait_ready", 32'(cif.cmd_ready), 32'd1);
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_lvl", 32'(lvl_sel), 32'd2);
        cif.cmd_valid = 1'b1;
        cyc = 0;
        while (busy && cyc < 50) begin step(); cyc++; end
        check("wait_status", 32'(status), 32'd1);
`endif
        step();

        // Reset in L3_SETTLE, then a clean replay with a spurious start.
        cif.cmd_valid = 1'b1; cif.cmd_mask = 5'b00000;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (lvl_sel != 2'd3 && cyc < 30) begin step(); cyc++; end
        check("l3_reached", 32'(lvl_sel), 32'd3);
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_vals("midrst");
        repeat (2) step();
        rst = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 3;
        while (busy && cyc < 50) begin step(); cyc++; end
        check("replay_cycles", 32'(cyc), 32'd12);
        check("replay_status", 32'(status), 32'd1);
        check("replay_o_out", 32'(o_out), 32'h18);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
